// File: rtl/framer_pkg.sv
// Types and constants shared by the packet framer and its tests.
// Word-count helper rounds a partial final word up.
package framer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_SEQ,
    S_PAYLOAD,
    S_CSUM,
    S_TAIL0,
    S_TAIL1
  } fsm_e;

  localparam logic [7:0] HDR_WORD0  = 8'hA5;
  localparam logic [7:0] HDR_WORD1  = 8'h5A;
  localparam logic [7:0] TAIL_WORD0 = 8'h0D;
  localparam logic [7:0] TAIL_WORD1 = 8'h0A;

  function automatic int unsigned word_count(input int unsigned len, input int unsigned per_word);
    return (len + per_word - 1) / per_word;
  endfunction

endpackage

// File: rtl/packet_framer_packer.sv
// Packs PackedNum narrow elements LSB-first into one word; flush_i closes a
// partial word early, leaving its unused upper elements zero.
module packet_framer_packer #(
  parameter int UnpackedWidth = 1,
  parameter int PackedNum     = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [UnpackedWidth-1:0]           data_i,
  input  logic                               flush_i,
  output logic                               valid_o,
  input  logic                               pop_i,
  output logic [UnpackedWidth*PackedNum-1:0] data_o
);

  localparam int CntWidth = (PackedNum > 1) ? $clog2(PackedNum) : 1;

  logic [PackedNum-1:0][UnpackedWidth-1:0] word_q, word_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic full_q, full_d;
  logic accept;

  // A completed word may be popped and a new one started in the same cycle.
  assign ready_o = !full_q || pop_i;
  assign accept  = valid_i && ready_o;
  assign valid_o = full_q;
  assign data_o  = word_q;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    if (pop_i) begin
      word_d = '0;
      full_d = 1'b0;
    end
    if (accept) begin
      word_d[cnt_q] = data_i;
      if (flush_i || cnt_q == CntWidth'(PackedNum - 1)) begin
        full_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/packet_framer.sv
// Frames a runtime-length element stream as header, optional sequence word,
// packed payload, optional XOR checksum and tail, through one output register.
module packet_framer
  import framer_pkg::*;
#(
  parameter int         UnpackedWidth = 1,
  parameter int         PackedNum     = 8,
  parameter int         MaxLenElems   = 4096,
  parameter logic [7:0] HeaderWord0   = HDR_WORD0,
  parameter logic [7:0] HeaderWord1   = HDR_WORD1,
  parameter logic [7:0] TailWord0     = TAIL_WORD0,
  parameter logic [7:0] TailWord1     = TAIL_WORD1,
  parameter bit         EnableSeq     = 1'b1,
  parameter bit         EnableCsum    = 1'b1,
  localparam int        PackedWidth   = UnpackedWidth * PackedNum,
  localparam int        LenWidth      = $clog2(MaxLenElems + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [LenWidth-1:0]      len_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [UnpackedWidth-1:0] unpacked_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [PackedWidth-1:0]   data_o,
  output logic                     busy_o,
  output logic [PackedWidth-1:0]   seq_o,
  output logic                     frame_done_o
);

  fsm_e                   state_q, state_d;
  logic [LenWidth-1:0]    len_q, len_d, elem_cnt_q, elem_cnt_d, word_cnt_q, word_cnt_d;
  logic [PackedWidth-1:0] csum_q, csum_d, seq_q, seq_d, out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;

  logic [LenWidth-1:0]    len_eff, words_total;
  logic                   fire, load_en, in_accept, last_fire;
  logic                   pk_ready, pk_valid, pk_flush, pk_pop;
  logic [PackedWidth-1:0] pk_data;

  assign len_eff = (len_i == '0 || 32'(len_i) > 32'(MaxLenElems)) ? LenWidth'(MaxLenElems) : len_i;
  assign words_total = LenWidth'(word_count(32'(len_q), 32'(PackedNum)));

  assign fire      = out_valid_q && ready_i;
  assign load_en   = !out_valid_q || ready_i;
  assign ready_o   = (state_q == S_PAYLOAD) && pk_ready && (elem_cnt_q < len_q);
  assign in_accept = valid_i && ready_o;
  assign pk_flush  = in_accept && (elem_cnt_q == len_q - 1'b1);
  assign last_fire = (state_q == S_PAYLOAD) && fire && (word_cnt_q == words_total - 1'b1);
  assign pk_pop    = (state_q == S_PAYLOAD) && pk_valid && load_en && !last_fire;

  assign valid_o = out_valid_q;
  assign data_o  = out_data_q;
  assign busy_o  = (state_q != S_IDLE);
  assign seq_o   = seq_q;

  packet_framer_packer #(
    .UnpackedWidth(UnpackedWidth),
    .PackedNum    (PackedNum)
  ) u_packer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .valid_i(valid_i && (state_q == S_PAYLOAD) && (elem_cnt_q < len_q)),
    .ready_o(pk_ready),
    .data_i (unpacked_i),
    .flush_i(pk_flush),
    .valid_o(pk_valid),
    .pop_i  (pk_pop),
    .data_o (pk_data)
  );

  // The state names the word currently held (or about to be held) in the output register.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    elem_cnt_d   = elem_cnt_q;
    word_cnt_d   = word_cnt_q;
    csum_d       = csum_q;
    seq_d        = seq_q;
    out_valid_d  = out_valid_q && !ready_i;
    out_data_d   = out_data_q;
    frame_done_o = 1'b0;
    unique case (state_q)
      S_IDLE: if (valid_i) begin
        len_d       = len_eff;
        elem_cnt_d  = '0;
        word_cnt_d  = '0;
        csum_d      = '0;
        out_valid_d = 1'b1;
        out_data_d  = PackedWidth'(HeaderWord0);
        state_d     = S_HDR0;
      end
      S_HDR0: if (fire) begin
        out_valid_d = 1'b1;
        out_data_d  = PackedWidth'(HeaderWord1);
        state_d     = S_HDR1;
      end
      S_HDR1: if (fire) begin
        if (EnableSeq) begin
          out_valid_d = 1'b1;
          out_data_d  = seq_q;
          state_d     = S_SEQ;
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_SEQ: if (fire) state_d = S_PAYLOAD;
      S_PAYLOAD: begin
        if (in_accept) elem_cnt_d = elem_cnt_q + 1'b1;
        if (fire) begin
          word_cnt_d = word_cnt_q + 1'b1;
          csum_d     = csum_q ^ out_data_q;
        end
        if (last_fire) begin
          out_valid_d = 1'b1;
          if (EnableCsum) begin
            out_data_d = csum_d;
            state_d    = S_CSUM;
          end else begin
            out_data_d = PackedWidth'(TailWord0);
            state_d    = S_TAIL0;
          end
        end else if (pk_pop) begin
          out_valid_d = 1'b1;
          out_data_d  = pk_data;
        end
      end
      S_CSUM: if (fire) begin
        out_valid_d = 1'b1;
        out_data_d  = PackedWidth'(TailWord0);
        state_d     = S_TAIL0;
      end
      S_TAIL0: if (fire) begin
        out_valid_d = 1'b1;
        out_data_d  = PackedWidth'(TailWord1);
        state_d     = S_TAIL1;
      end
      S_TAIL1: if (fire) begin
        frame_done_o = 1'b1;
        seq_d        = seq_q + 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      elem_cnt_q  <= '0;
      word_cnt_q  <= '0;
      csum_q      <= '0;
      seq_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      elem_cnt_q  <= elem_cnt_d;
      word_cnt_q  <= word_cnt_d;
      csum_q      <= csum_d;
      seq_q       <= seq_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule
